// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// Weight codes are 3-bit two's-complement multiples of the multiplicand.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [2:0] WT_ZERO = 3'b000;
  localparam logic [2:0] WT_P1   = 3'b001;
  localparam logic [2:0] WT_P2   = 3'b010;
  localparam logic [2:0] WT_N2   = 3'b110;
  localparam logic [2:0] WT_N1   = 3'b111;

  // Recode one overlapping multiplier triplet {b[2k+1], b[2k], b[2k-1]}.
  function automatic logic [2:0] booth_enc(input logic [2:0] triplet);
    logic [2:0] w_code;
    case (triplet)
      3'b000, 3'b111: w_code = WT_ZERO;
      3'b001, 3'b010: w_code = WT_P1;
      3'b011:         w_code = WT_P2;
      3'b100:         w_code = WT_N2;
      default:        w_code = WT_N1;
    endcase
    return w_code;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: weight * a, sign-extended to 2W.
// W+2 bits of headroom cover -2 * (-2^(W-1)) without overflow.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]     weight,
  input  logic [W-1:0]   a,
  output logic [2*W-1:0] pp
);

  logic [W+1:0] w_a_ext;
  logic [W+1:0] w_a_dbl;
  logic [W+1:0] w_pp_n;

  assign w_a_ext = {{2{a[W-1]}}, a};
  assign w_a_dbl = {w_a_ext[W:0], 1'b0};

  always_comb begin
    w_pp_n = '0;
    case (weight)
      WT_P1:   w_pp_n = w_a_ext;
      WT_P2:   w_pp_n = w_a_dbl;
      WT_N1:   w_pp_n = -w_a_ext;
      WT_N2:   w_pp_n = -w_a_dbl;
      default: w_pp_n = '0;
    endcase
  end

  assign pp = {{(W-2){w_pp_n[W+1]}}, w_pp_n};

endmodule

// File: rtl/booth_iter_mult_ctrl.sv
// Iterative signed radix-4 Booth multiplier: one Booth digit per clock into a
// 2W-bit accumulator, with valid/ready handshakes on operand and result sides.
module booth_iter_mult_ctrl
  import booth_pkg::*;
#(
  parameter int W      = 8,
  parameter int STEP_W = $clog2(W/2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W/2 - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [2*W-1:0]     r_acc;
  logic [W-1:0]       r_a_q;
  logic [W-1:0]       r_b_q;
  logic [STEP_W-1:0]  r_step;

  logic               w_load;
  logic [W:0]         w_b_ext;
  logic [2:0]         w_trip [W/2];
  logic [2:0]         w_weight;
  logic [2*W-1:0]     w_pp;
  logic [2*W-1:0]     w_pp_shift;

  // Multiplier with the implicit b[-1]=0 appended, then split into digit triplets.
  assign w_b_ext = {r_b_q, 1'b0};

  for (genvar gi = 0; gi < W/2; gi++) begin : g_digit
    assign w_trip[gi] = w_b_ext[2*gi +: 3];
  end

  assign w_weight   = booth_enc(w_trip[r_step]);
  assign w_pp_shift = w_pp << {r_step, 1'b0};

  booth_pp_gen #(.W(W)) u_pp_gen (
    .weight (w_weight),
    .a      (r_a_q),
    .pp     (w_pp)
  );

  assign w_load = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_load) w_state_next = RUN;
      RUN:  if (r_step == LAST_STEP) w_state_next = DONE;
      DONE: begin
        if (out_ready) w_state_next = in_valid ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs; product is masked outside DONE so partial sums never leak.
  always_comb begin
    in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN);
    product   = (r_state == DONE) ? r_acc : '0;
  end

  // Operand capture and digit-serial accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_a_q  <= '0;
      r_b_q  <= '0;
      r_step <= '0;
    end else if (w_load) begin
      r_acc  <= '0;
      r_a_q  <= a;
      r_b_q  <= b;
      r_step <= '0;
    end else if (r_state == RUN) begin
      r_acc  <= r_acc + w_pp_shift;
      r_step <= r_step + STEP_W'(1);
    end
  end

endmodule
